// File: rtl/render_pkg.sv
// Shared constants for the full-screen renderers and the render sequencer.
package render_pkg;

  localparam int SCR_GREETING  = 0;
  localparam int SCR_GAME_OVER = 1;
  localparam int SCR_WIN       = 2;
  localparam int SCR_PLAY      = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PIXELS   = SCREEN_W * SCREEN_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/m_render_ctrl.sv
// Render sequencer: enables one full-screen renderer per request and forwards
// its pixel stream to the VGA adapter with a qualified, registered plot strobe.
module m_render_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PIXELS  = render_pkg::PIXELS,
  parameter int TIMEOUT = 20480
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [1:0]            req_screen,
  output logic                  req_ready,
  output logic [NUM_SRC-1:0]    src_enable,
  input  logic [NUM_SRC-1:0]    src_finished,
  input  logic [8*NUM_SRC-1:0]  src_x,
  input  logic [7*NUM_SRC-1:0]  src_y,
  input  logic [12*NUM_SRC-1:0] src_color,
  output logic [7:0]            VGA_X,
  output logic [6:0]            VGA_Y,
  output logic [11:0]           VGA_COLOR,
  output logic                  VGA_PLOT,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import render_pkg::*;

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // A watchdog shorter than one full frame would abort every screen.
  localparam int WD_MAX = (TIMEOUT > PIXELS + 2) ? TIMEOUT : PIXELS + 3;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_MAX - 1);

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic              en_q;
  logic [WD_W-1:0]   wdog;

  logic              fin_sel;
  logic              pix_valid;
  logic              id_ok;
  logic [7:0]        mux_x;
  logic [6:0]        mux_y;
  logic [11:0]       mux_color;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    src_enable = '0;
    fin_sel    = src_finished[sel];
    mux_x      = src_x[8*sel +: 8];
    mux_y      = src_y[7*sel +: 7];
    mux_color  = src_color[12*sel +: 12];
    id_ok      = (32'(req_screen) < NUM_SRC);
    // Enable drops the same cycle finished is seen so the renderer never restarts.
    if ((state == START || state == RUN) && !fin_sel) src_enable[sel] = 1'b1;
    pix_valid  = en_q && (state == RUN) && !fin_sel;
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      en_q  <= 1'b0;
      wdog  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      done <= 1'b0;
      err  <= 1'b0;
      en_q <= src_enable[sel];
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (id_ok) begin
              sel   <= SEL_W'(req_screen);
              state <= START;
            end else begin
              err <= 1'b1;
            end
          end
        end
        START: begin
          wdog  <= '0;
          state <= RUN;
        end
        RUN: begin
          if (fin_sel) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (wdog == WD_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          if (!fin_sel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel register: one cycle behind the renderer; coordinates hold outside RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      VGA_PLOT  <= 1'b0;
    end else begin
      VGA_PLOT <= pix_valid;
      if (state == RUN) begin
        VGA_X     <= mux_x;
        VGA_Y     <= mux_y;
        VGA_COLOR <= mux_color;
      end
    end
  end

endmodule

// File: tb/tb_m_render_ctrl.sv
// Scoreboard bench for m_render_ctrl with behavioural renderer models on every source.
module tb_m_render_ctrl;

  localparam int NUM_SRC = 4;
  localparam int W       = 80;
  localparam int H       = 60;
  localparam int P       = W * H;
  localparam int TO      = 5200;
  localparam int RST_PIX = 1250;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] c;
  } pix_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  req_valid = 1'b0;
  logic [1:0]            req_screen = '0;
  logic                  req_ready;
  logic [NUM_SRC-1:0]    src_enable;
  logic [NUM_SRC-1:0]    src_finished;
  logic [8*NUM_SRC-1:0]  src_x;
  logic [7*NUM_SRC-1:0]  src_y;
  logic [12*NUM_SRC-1:0] src_color;
  logic [7:0]            VGA_X;
  logic [6:0]            VGA_Y;
  logic [11:0]           VGA_COLOR;
  logic                  VGA_PLOT;
  logic                  busy;
  logic                  done;
  logic                  err;

  m_render_ctrl #(.NUM_SRC(NUM_SRC), .PIXELS(P), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_screen(req_screen), .req_ready(req_ready),
    .src_enable(src_enable), .src_finished(src_finished),
    .src_x(src_x), .src_y(src_y), .src_color(src_color),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .VGA_PLOT(VGA_PLOT),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Renderer model: one pixel per enabled cycle in raster order, finished one
  // enabled cycle after the last pixel, counter cleared whenever disabled.
  int                 cnt [NUM_SRC];
  int                 hold[NUM_SRC];
  logic [7:0]         xr  [NUM_SRC];
  logic [6:0]         yr  [NUM_SRC];
  logic [11:0]        cr  [NUM_SRC];
  logic [11:0]        seed[NUM_SRC];
  bit                 never_fin[NUM_SRC];
  logic [NUM_SRC-1:0] fin_r = '0;
  int                 fin_hold_cfg = 0;

  function automatic logic [11:0] color_of(int src, int i);
    return 12'(i * 37 + src * 293) ^ seed[src];
  endfunction

  function automatic pix_t ref_pix(int src, int i);
    pix_t p;
    p.x = 8'(i % W);
    p.y = 7'(i / W);
    p.c = color_of(src, i);
    return p;
  endfunction

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt[i] = 0; hold[i] = 0; xr[i] = 8'hFF; yr[i] = 7'h7F; cr[i] = '0;
      seed[i] = '0; never_fin[i] = 1'b0;
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_enable[i]) begin
        if (cnt[i] < P) begin
          xr[i]  <= 8'(cnt[i] % W);
          yr[i]  <= 7'(cnt[i] / W);
          cr[i]  <= color_of(i, cnt[i]);
          cnt[i] <= cnt[i] + 1;
        end else if (!never_fin[i]) begin
          fin_r[i] <= 1'b1;
          hold[i]  <= fin_hold_cfg;
        end
      end else begin
        cnt[i] <= 0;
        xr[i]  <= 8'hFF;
        yr[i]  <= 7'h7F;
        cr[i]  <= '0;
        if (fin_r[i]) begin
          if (hold[i] == 0) fin_r[i] <= 1'b0;
          else hold[i] <= hold[i] - 1;
        end
      end
    end
  end

  always_comb begin
    src_x = '0; src_y = '0; src_color = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_x[8*i +: 8]      = xr[i];
      src_y[7*i +: 7]      = yr[i];
      src_color[12*i +: 12] = cr[i];
    end
  end
  assign src_finished = fin_r;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor state
  pix_t               sb[$];
  pix_t               mon_exp;
  bit                 sb_on = 1'b0;
  int                 cur = 0;
  int                 plots, first_plot, last_plot;
  int                 done_cnt, err_cnt, done_cyc, err_cyc, fin_cyc;
  int                 bad_en, bad_ready;
  int                 ff_seen = 0;
  logic [NUM_SRC-1:0] err_en;
  logic               en_at_fin;

  always @(negedge clock) begin
    if (!reset) begin
      if (VGA_PLOT) begin
        plots++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
        if (VGA_X == 8'hFF) ff_seen++;
        if (sb_on) begin
          if (sb.size() == 0) begin
            check("plot_overrun", 64'(plots), 64'(P));
          end else begin
            mon_exp = sb.pop_front();
            check("pixel", {VGA_X, VGA_Y, VGA_COLOR}, mon_exp);
          end
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; err_en = src_enable; end
      if (src_finished[cur] && fin_cyc < 0) begin
        fin_cyc   = cyc;
        en_at_fin = src_enable[cur];
      end
      if ((src_enable & ~(NUM_SRC'(1) << cur)) != '0) bad_en++;
      if (src_finished[cur] && src_enable[cur]) bad_en++;
      if (req_ready && src_finished[cur]) bad_ready++;
    end
  end

  task automatic setup_frame(input int scr, input bit timeout_mode, input bit use_sb);
    for (int i = 0; i < NUM_SRC; i++) never_fin[i] = 1'b0;
    never_fin[scr] = timeout_mode;
    seed[scr]      = 12'($urandom);
    fin_hold_cfg   = int'($urandom_range(0, 3));
    cur        = scr;
    plots      = 0;  first_plot = -1; last_plot = -1;
    done_cnt   = 0;  err_cnt = 0;  done_cyc = -1; err_cyc = -1; fin_cyc = -1;
    bad_en     = 0;  bad_ready = 0; err_en = '1; en_at_fin = 1'b1;
    sb.delete();
    sb_on = use_sb;
    if (use_sb) for (int i = 0; i < P; i++) sb.push_back(ref_pix(scr, i));
  endtask

  task automatic run_frame(input int scr, input bit timeout_mode, input bit hold_req);
    int t;
    int n;
    logic [NUM_SRC-1:0] onehot;
    onehot      = '0;
    onehot[scr] = 1'b1;
    setup_frame(scr, timeout_mode, !timeout_mode);
    req_valid  = 1'b1;
    req_screen = 2'(scr);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    check("req_accepted", 64'(req_ready), 64'(1));
    t = cyc;
    @(negedge clock);
    check("enable_at_start", 64'(src_enable), 64'(onehot));
    check("busy_at_start", 64'(busy), 64'(1));
    // A competing request held during the frame must be ignored.
    req_valid  = hold_req;
    req_screen = 2'(scr + 2);
    n = 0;
    while (!done && !err && n < TO + 50) begin @(negedge clock); n++; end
    req_valid = 1'b0;
    check("frame_ended", 64'(done | err), 64'(1));
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    check("back_to_idle", 64'(req_ready), 64'(1));
    check("finished_clear_at_idle", 64'(src_finished[scr]), 64'(0));
    @(negedge clock);
    if (timeout_mode) begin
      check("err_count", 64'(err_cnt), 64'(1));
      check("done_count_on_timeout", 64'(done_cnt), 64'(0));
      check("err_cycle", 64'(err_cyc), 64'(t + TO + 2));
      check("enable_after_err", 64'(err_en), 64'(0));
    end else begin
      check("plot_count", 64'(plots), 64'(P));
      check("first_plot_cycle", 64'(first_plot), 64'(t + 3));
      check("last_plot_cycle", 64'(last_plot), 64'(t + P + 2));
      check("done_count", 64'(done_cnt), 64'(1));
      check("err_count", 64'(err_cnt), 64'(0));
      check("done_after_finished", 64'(done_cyc), 64'(fin_cyc + 1));
      check("enable_low_when_finished", 64'(en_at_fin), 64'(0));
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
    end
    check("foreign_enable", 64'(bad_en), 64'(0));
    check("ready_while_finished", 64'(bad_ready), 64'(0));
  endtask

  task automatic reset_mid_frame();
    int n;
    setup_frame(0, 1'b0, 1'b0);
    req_valid  = 1'b1;
    req_screen = 2'd0;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (plots < RST_PIX && n < P) begin @(negedge clock); n++; end
    check("reached_reset_point", 64'(plots >= RST_PIX), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {VGA_X, VGA_Y, VGA_COLOR, VGA_PLOT, busy, done, err, src_enable}, 64'(0));
    check("async_reset_ready", 64'(req_ready), 64'(1));
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("no_done_from_reset", 64'(done_cnt), 64'(0));
    check("no_err_from_reset", 64'(err_cnt), 64'(0));
    check("idle_after_reset", 64'(busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached after %0d tests", tests);
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          {VGA_X, VGA_Y, VGA_COLOR, VGA_PLOT, busy, done, err, src_enable}, 64'(0));
    check("reset_ready", 64'(req_ready), 64'(1));
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", 64'(req_ready), 64'(1));

    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b1);
    reset_mid_frame();
    run_frame(0, 1'b0, 1'b0);
    repeat (2) run_frame(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));

    check("unselected_source_on_vga_x", 64'(ff_seen), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m_render_ctrl.md
# m_render_ctrl

Sequencer and pixel-mux stage that sits directly downstream of the full-screen renderers (greeting, game-over, win, playfield). On a screen request it enables exactly one renderer and forwards that renderer's pixel stream to the VGA adapter with a qualified plot strobe. It waits for the renderer's `finished`, drops its enable, and reports completion or timeout to the game FSM. It is the only block that drives the adapter's write port.

## Interface
- `NUM_SRC`, 4: number of renderer sources; screen id = source index.
- `PIXELS`, 19200: pixels per full screen (160x120).
- `TIMEOUT`, 20480: maximum cycles in RUN before abort; must exceed `PIXELS`+2.

- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs.
- `req_valid`  in  1: screen request from the game FSM.
- `req_screen`  in  2: source index to render.
- `req_ready`  out  1: high only in IDLE.
- `src_enable`  out  NUM_SRC: one-hot enable to renderers.
- `src_finished`  in  NUM_SRC: renderer `finished` flags.
- `src_x`  in  8*NUM_SRC: packed renderer X; source i at bits [8i+7:8i].
- `src_y`  in  7*NUM_SRC: packed renderer Y.
- `src_color`  in  12*NUM_SRC: packed renderer colour.
- `VGA_X`  out  8, `VGA_Y`  out  7, `VGA_COLOR`  out  12: registered pixel to adapter.
- `VGA_PLOT`  out  1: adapter write enable; one per valid pixel.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse at completion.
- `err`  out  1: one-cycle pulse on timeout or invalid id.

## Operation
- Reset: state IDLE. All outputs 0 except `req_ready`=1. `sel`, `en_q`, and the watchdog are cleared.
- IDLE: on `req_valid` with `req_screen` < NUM_SRC, latch `sel` and go to START. An id >= NUM_SRC pulses `err`, and the state stays IDLE.
- START: one cycle; clear the watchdog; go to RUN.
- RUN: the watchdog increments each cycle.
  - On `src_finished[sel]`=1, go to DONE.
  - On watchdog == TIMEOUT-1, pulse `err` and go to DONE.
- DONE: pulse `done` on entry, but only if no timeout occurred. Stay until `src_finished[sel]`=0, then go to IDLE.
- `src_enable[sel]` is combinational: (state==START or RUN) and not `src_finished[sel]`.
  - It drops in the same cycle `finished` is seen, so the renderer never restarts its counter.
  - All other bits of `src_enable` are always 0.
- `en_q` = registered `src_enable[sel]`. A pixel is valid when `en_q`=1, state==RUN, and `src_finished[sel]`=0.
- Output register, updated every cycle:
  - `VGA_X`/`VGA_Y`/`VGA_COLOR` <= the selected source's values.
  - `VGA_PLOT` <= pixel valid.
  - Outside RUN, `VGA_PLOT` is 0 and `VGA_X`/`VGA_Y`/`VGA_COLOR` hold their values.
- `req_valid` outside IDLE is ignored. The requester must hold it until it sees `req_ready`.

## Timing
- Latency: renderer output to `VGA_*`/`VGA_PLOT` is 1 cycle.
- Exactly `PIXELS` `VGA_PLOT` pulses per completed screen. They are contiguous (no gaps) for a renderer that advances one pixel per enabled cycle.
- Request accepted in cycle t:
  - `src_enable` rises at t+1 (START).
  - First `VGA_PLOT` at t+3.
  - Last `VGA_PLOT` at t+PIXELS+2.
- `finished` seen in cycle f: enable is low in f; `done` occurs at f+1; IDLE is reached one cycle after `finished` clears.
- A timeout aborts mid-frame. The next request restarts the renderer from its counter reset value, which is its responsibility.
- `reset` mid-frame: enables and `VGA_PLOT` drop immediately (asynchronous). No `done` or `err` pulse.

## Structure
- Shared package `render_pkg`:
  - Screen id constants: SCR_GREETING=0, SCR_GAME_OVER=1, SCR_WIN=2, SCR_PLAY=3.
  - `SCREEN_W`=160, `SCREEN_H`=120, `PIXELS`.
  - State encoding: IDLE, START, RUN, DONE.
- Watchdog width = clog2(TIMEOUT+1).
- No sub-module; the mux and FSM are inline.

## Test plan
- Request screen 1 with a behavioural renderer model:
  - 19200 `VGA_PLOT` pulses.
  - First pixel (0,0), last pixel (159,119), colour passed through.
  - One `done` pulse, no `err`.
- `finished` rising in cycle f:
  - `src_enable[1]`=0 in f.
  - No extra plot of pixel (0,0) after the last pixel.
  - `req_ready`=1 after `finished` clears.
- Renderer model that never finishes:
  - `err` pulse at RUN cycle TIMEOUT-1, enable low next cycle, no `done`.
  - IDLE reached afterwards.
- `req_screen`=3 request:
  - Only `src_enable[3]` is ever high.
  - Sources 0–2 driving X=0xFF are never seen on `VGA_X`.
- `reset` asserted at pixel 5000: all outputs 0 asynchronously. A new request for screen 0 then completes with 19200 pulses.
- `req_valid` held high with a new id during RUN: ignored; the current screen completes unchanged.
